ps2_rx_frame: RTL and testbench

PS/2 device-to-host receiver that sits directly upstream of the keyboard display stage. It samples the raw ps2_clk/ps2_data lines and deglitches them, then deserialises 11-bit frames: start, 8 data bits LSB-first, odd parity, stop. Each valid byte is presented on ps2dis_data with a one-cycle ps2dis_recFlag strobe, matching the consumer's input contract. Corrupt or stalled frames are dropped and flagged.

---
 rtl/ps2_rx_frame_pkg.sv | 22 ++
 rtl/ps2_rx_frame_if.sv | 20 ++
 rtl/ps2_rx_frame_sync_filter.sv | 64 ++++++
 rtl/ps2_rx_frame.sv | 132 +++++++++++++
 tb/tb_ps2_rx_frame.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_frame_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding, frame geometry,
// the break code seen by the display stage, and a counter-width helper.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        DATA   = 4'b0010,
        PARITY = 4'b0100,
        STOP   = 4'b1000
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

    // Bits needed for a counter that must hold values 0..n-1 (at least 1).
    function automatic int ps2_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Receiver-to-display bundle: received byte, its strobe, error pulses and
// the running byte count. The receiver drives it, the display stage reads it.
interface ps2_rx_frame_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] ps2dis_data;
    logic                     ps2dis_recFlag;
    logic                     parity_err;
    logic                     frame_err;
    logic [7:0]               rx_count;

    modport master (
        output ps2dis_data, ps2dis_recFlag, parity_err, frame_err, rx_count
    );

    modport slave (
        input ps2dis_data, ps2dis_recFlag, parity_err, frame_err, rx_count
    );

endinterface

// File: rtl/ps2_rx_frame_sync_filter.sv
// Brings the asynchronous PS/2 lines into the clk domain, removes short
// glitches from the clock line and produces a one-cycle pulse on each
// falling edge of the cleaned clock, alongside the synchronised data bit.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic sample_evt_o,
    output logic data_s_o
);

    localparam int             FW       = ps2_cnt_w(FILTER_LEN);
    localparam logic [FW-1:0]  FLT_LAST = FW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_filt_q;
    logic                   clk_filt_prev_q;
    logic [FW-1:0]          flt_cnt_q;
    logic                   clk_s;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    // Synchroniser chains; reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN
    // consecutive samples disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
            flt_cnt_q       <= '0;
        end else begin
            clk_filt_prev_q <= clk_filt_q;
            if (clk_s == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                clk_filt_q <= clk_s;
                flt_cnt_q  <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end
    end

    assign sample_evt_o = clk_filt_prev_q & ~clk_filt_q;
    assign data_s_o     = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver. Deserialises start/8 data/odd parity/
// stop frames and hands valid bytes to the display stage with a one-cycle
// strobe; bad or stalled frames are dropped with an error pulse.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_rx_frame_if.master dis
);

    localparam int              TMO_W    = ps2_cnt_w(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic                       sample_evt;
    logic                       data_s;

    ps2_state_t                 state_q;
    logic [PS2_DATA_BITS-1:0]   shift_q;
    logic [2:0]                 bitcnt_q;
    logic                       par_q;
    logic [TMO_W-1:0]           tmo_q;
    logic                       ok_q;
    logic                       perr_q;
    logic                       ferr_q;

    logic [PS2_DATA_BITS-1:0]   data_q;
    logic                       rec_q;
    logic                       perr_out_q;
    logic                       ferr_out_q;
    logic [7:0]                 cnt_q;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .sample_evt_o (sample_evt),
        .data_s_o     (data_s)
    );

    // Frame FSM plus stall timer. Verdicts (ok/parity/frame) are registered
    // here and turned into outputs by the next stage. A sample event in the
    // same cycle as the timer expiring takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            ok_q     <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            ok_q   <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;

            if (sample_evt || state_q == IDLE) tmo_q <= '0;
            else                               tmo_q <= tmo_q + TMO_W'(1);

            if (sample_evt) begin
                case (state_q)
                    IDLE: begin
                        // A high level here is a spurious start: ignore it.
                        if (!data_s) begin
                            state_q  <= DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q[bitcnt_q] <= data_s;
                        bitcnt_q          <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= data_s;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!data_s)                 ferr_q <= 1'b1;
                        else if (^shift_q ^ par_q)   ok_q   <= 1'b1;
                        else                         perr_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
                state_q  <= IDLE;
                bitcnt_q <= '0;
                ferr_q   <= 1'b1;
            end
        end
    end

    // Output stage: publishes the verdict one cycle later. shift_q is stable
    // here because the next data bit is at least two sample events away.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            rec_q      <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rec_q      <= ok_q;
            perr_out_q <= perr_q;
            ferr_out_q <= ferr_q;
            if (ok_q) begin
                data_q <= shift_q;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end

    assign dis.ps2dis_data    = data_q;
    assign dis.ps2dis_recFlag = rec_q;
    assign dis.parity_err     = perr_out_q;
    assign dis.frame_err      = ferr_out_q;
    assign dis.rx_count       = cnt_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed and randomised PS/2 frames against a frame-level reference model.
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int TMO = 200;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_frame_if dis();

    ps2_rx_frame #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .dis      (dis)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed events
    logic [7:0] rec_q[$];
    int perr_n = 0, ferr_n = 0, excl_bad = 0, wide_bad = 0;
    int cyc = 0, ferr_cyc = 0, last_fall_cyc = 0;
    logic prev_rec = 1'b0, prev_perr = 1'b0, prev_ferr = 1'b0;

    // Reference model state
    logic [7:0] exp_q[$];
    int         exp_perr = 0, exp_ferr = 0, exp_cnt = 0;
    logic [7:0] exp_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (dis.ps2dis_recFlag) rec_q.push_back(dis.ps2dis_data);
        if (dis.parity_err) perr_n++;
        if (dis.frame_err) begin
            ferr_n++;
            ferr_cyc = cyc;
        end
        if (int'(dis.ps2dis_recFlag) + int'(dis.parity_err) + int'(dis.frame_err) > 1)
            excl_bad++;
        if ((dis.ps2dis_recFlag && prev_rec) || (dis.parity_err && prev_perr) ||
            (dis.frame_err && prev_ferr))
            wide_bad++;
        prev_rec  = dis.ps2dis_recFlag;
        prev_perr = dis.parity_err;
        prev_ferr = dis.frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set during the high phase, device pulls clk low.
    // Optional 2-cycle low glitch early in the high phase.
    task automatic send_bit(input logic b, input int half, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(half / 3);
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(half - half / 3 - 2);
        end else begin
            wait_cyc(half);
        end
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(half);
        ps2_clk = 1'b1;
    endtask

    // Full frame plus the model's verdict for it.
    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop,
                              input int half, input bit glitch);
        logic par;
        par = (~^b) ^ par_flip;
        send_bit(1'b0, half, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], half, glitch);
        send_bit(par, half, glitch);
        send_bit(stop, half, glitch);
        ps2_data = 1'b1;
        if (!stop)         exp_ferr++;
        else if (par_flip) exp_perr++;
        else begin
            exp_q.push_back(b);
            exp_cnt  = (exp_cnt + 1) % 256;
            exp_data = b;
        end
    endtask

    task automatic verify(input string tag);
        wait_cyc(12);
        check({tag, "/nrec"}, rec_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rec_q.size() > 0) check({tag, "/byte"}, rec_q.pop_front(), e);
        end
        rec_q.delete();
        check({tag, "/perr"}, perr_n, exp_perr);
        check({tag, "/ferr"}, ferr_n, exp_ferr);
        check({tag, "/count"}, dis.rx_count, exp_cnt);
        check({tag, "/data"}, dis.ps2dis_data, exp_data);
        check({tag, "/excl"}, excl_bad, 0);
        check({tag, "/width"}, wide_bad, 0);
    endtask

    initial begin
        int f0;
        int fe0;
        int k;
        logic [7:0] b;

        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(1);
        check("reset/data", dis.ps2dis_data, 8'h00);
        check("reset/rec", dis.ps2dis_recFlag, 1'b0);
        check("reset/perr", dis.parity_err, 1'b0);
        check("reset/ferr", dis.frame_err, 1'b0);
        check("reset/count", dis.rx_count, 8'h00);

        // Single valid frame
        send_frame(8'h1C, 0, 1, 60, 0);
        verify("single");

        // Back-to-back sequence
        send_frame(8'h1C, 0, 1, 60, 0);
        send_frame(PS2_BREAK_CODE, 0, 1, 60, 0);
        send_frame(8'h1C, 0, 1, 60, 0);
        verify("seq");

        // Bad parity, then bad stop with good parity
        send_frame(8'h1C, 1, 1, 60, 0);
        verify("parity");
        send_frame(8'h1C, 0, 0, 60, 0);
        verify("stop");

        // Stall after 5 data bits
        b = 8'hA7;
        fe0 = ferr_n;
        send_bit(1'b0, 60, 0);
        for (int i = 0; i < 5; i++) send_bit(b[i], 60, 0);
        ps2_data = 1'b1;
        f0 = last_fall_cyc;
        wait_cyc(TMO + 60);
        exp_ferr++;
        check("tmo/pulses", ferr_n - fe0, 1);
        check("tmo/delay", (ferr_cyc - f0 >= TMO + 4) && (ferr_cyc - f0 <= TMO + 12), 1'b1);
        send_frame(8'h32, 0, 1, 60, 0);
        verify("tmo");

        // Glitched clock
        send_frame(8'h1C, 0, 1, 60, 1);
        verify("glitch");

        // Randomised frames, mostly valid
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 9);
            send_frame(b, k == 8, k != 9, $urandom_range(9, 30), 0);
            verify("rand");
        end

        // Reset after 4 data bits
        b = 8'h5A;
        send_bit(1'b0, 60, 0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 60, 0);
        ps2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("midrst/data", dis.ps2dis_data, 8'h00);
        check("midrst/count", dis.rx_count, 8'h00);
        check("midrst/flags", {dis.ps2dis_recFlag, dis.parity_err, dis.frame_err}, 3'b000);
        exp_cnt  = 0;
        exp_data = 8'h00;
        rec_q.delete();
        wait_cyc(TMO + 100);
        verify("midrst_quiet");
        send_frame(8'h5A, 0, 1, 60, 0);
        verify("midrst");

        // Counter wrap: restart from zero and send 256 valid frames
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        exp_cnt  = 0;
        exp_data = 8'h00;
        rec_q.delete();
        for (int n = 0; n < 255; n++) send_frame(8'($urandom_range(0, 255)), 0, 1, 9, 0);
        verify("wrap255");
        send_frame(8'($urandom_range(0, 255)), 0, 1, 9, 0);
        verify("wrap256");
        check("wrap/zero", dis.rx_count, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
